// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the program loader.
// State encoding, default byte width and the HALT terminator word.
package loader_pkg;

    localparam int          NB_BYTE_DEFAULT   = 8;
    localparam logic [15:0] HALT_WORD_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        S_HIGH  = 2'd0,   // waiting for the upper byte of a word
        S_LOW   = 2'd1,   // waiting for the lower byte of a word
        S_CHECK = 2'd2,   // waiting for the checksum byte (checksum builds only)
        S_DONE  = 2'd3    // image loaded, processor released
    } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream in / instruction-memory write port out, plus load status.
// The master modport is the loader; the slave modport is the surrounding
// system (UART receiver, instruction memory and processor reset control).
interface program_loader_if
    import loader_pkg::*;
#(
    parameter int NB_BYTE        = NB_BYTE_DEFAULT,
    parameter int NB_INSTRUCTION = 2 * NB_BYTE,
    parameter int NB_ADDR        = 10
);

    logic [NB_BYTE-1:0]        i_rx_data;
    logic                      i_rx_valid;
    logic                      i_restart;
    logic                      o_wr_en;
    logic [NB_ADDR-1:0]        o_wr_addr;
    logic [NB_INSTRUCTION-1:0] o_wr_data;
    logic                      o_loading;
    logic                      o_done;
    logic                      o_overflow;
    logic                      o_error;

    modport master (
        input  i_rx_data, i_rx_valid, i_restart,
        output o_wr_en, o_wr_addr, o_wr_data,
        output o_loading, o_done, o_overflow, o_error
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_restart,
        input  o_wr_en, o_wr_addr, o_wr_data,
        input  o_loading, o_done, o_overflow, o_error
    );

endinterface

// File: rtl/program_loader_checksum.sv
// XOR accumulator over the accepted image bytes, with clear and compare.
// Only compiled when PROGRAM_LOADER_CHECKSUM_EN is defined; the default
// build has no checksum logic at all.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
module loader_checksum
    import loader_pkg::*;
#(
    parameter int NB_BYTE = NB_BYTE_DEFAULT
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_accum,
    input  logic [NB_BYTE-1:0] i_byte,
    input  logic [NB_BYTE-1:0] i_expected,
    output logic               o_mismatch
);

    logic [NB_BYTE-1:0] r_xor;

    // Running XOR of every accepted byte; restart starts a fresh image.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_xor <= '0;
        end else if (i_accum) begin
            r_xor <= r_xor ^ i_byte;
        end
    end

    assign o_mismatch = (r_xor != i_expected);

endmodule
`endif

// File: rtl/program_loader.sv
// Program loader: assembles big-endian byte pairs from the UART into
// instruction words and writes them to instruction memory from address 0.
// Loading stops on the HALT word or when the last address has been written.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (trailing XOR checksum
// byte after HALT, mismatch reported on o_error).
module program_loader
    import loader_pkg::*;
#(
    parameter int                        NB_BYTE        = NB_BYTE_DEFAULT,
    parameter int                        NB_INSTRUCTION = 2 * NB_BYTE,
    parameter int                        NB_ADDR        = 10,
    parameter int                        ROM_DEPTH      = 2 ** NB_ADDR,
    parameter logic [NB_INSTRUCTION-1:0] HALT_WORD      = HALT_WORD_DEFAULT
) (
    input  logic             i_clock,
    input  logic             i_reset,
    program_loader_if.master bus
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(ROM_DEPTH - 1);

    state_t                    r_state,    w_next_state;
    logic [NB_BYTE-1:0]        r_hi,       w_hi_next;
    logic [NB_ADDR-1:0]        r_addr,     w_addr_next;
    logic                      r_wr_en,    w_wr_en_next;
    logic [NB_ADDR-1:0]        r_wr_addr,  w_wr_addr_next;
    logic [NB_INSTRUCTION-1:0] r_wr_data,  w_wr_data_next;
    logic                      r_overflow, w_overflow_next;
    logic [NB_INSTRUCTION-1:0] w_word;

    assign w_word = {r_hi, bus.i_rx_data};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic r_error;
    logic w_chk_strobe;
    logic w_accept;
    logic w_mismatch;

    // A data byte counts towards the checksum only when the FSM consumes it.
    assign w_accept = bus.i_rx_valid && !bus.i_restart &&
                      ((r_state == S_HIGH) || (r_state == S_LOW));

    loader_checksum #(
        .NB_BYTE    (NB_BYTE)
    ) u_checksum (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (bus.i_restart),
        .i_accum    (w_accept),
        .i_byte     (bus.i_rx_data),
        .i_expected (bus.i_rx_data),
        .o_mismatch (w_mismatch)
    );

    // Sticky checksum error, evaluated when the checksum byte arrives.
    always_ff @(posedge i_clock) begin
        if (i_reset || bus.i_restart) begin
            r_error <= 1'b0;
        end else if (w_chk_strobe && w_mismatch) begin
            r_error <= 1'b1;
        end
    end

    assign bus.o_error = r_error;
`else
    assign bus.o_error = 1'b0;
`endif

    // Next-state, byte assembly, address counter and write-port decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        w_next_state    = r_state;
        w_hi_next       = r_hi;
        w_addr_next     = r_addr;
        w_wr_en_next    = 1'b0;
        w_wr_addr_next  = r_wr_addr;
        w_wr_data_next  = r_wr_data;
        w_overflow_next = r_overflow;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        w_chk_strobe    = 1'b0;
`endif
        if (bus.i_restart) begin
            // Restart wins over a same-cycle byte, which is discarded.
            w_next_state    = S_HIGH;
            w_hi_next       = '0;
            w_addr_next     = '0;
            w_overflow_next = 1'b0;
        end else begin
            case (r_state)
                S_HIGH: begin
                    if (bus.i_rx_valid) begin
                        w_hi_next    = bus.i_rx_data;
                        w_next_state = S_LOW;
                    end
                end
                S_LOW: begin
                    if (bus.i_rx_valid) begin
                        w_wr_en_next   = 1'b1;
                        w_wr_addr_next = r_addr;
                        w_wr_data_next = w_word;
                        // Saturate at the last slot so the counter never wraps.
                        if (r_addr != LAST_ADDR) begin
                            w_addr_next = r_addr + NB_ADDR'(1);
                        end
                        if (w_word == HALT_WORD) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            w_next_state = S_CHECK;
`else
                            w_next_state = S_DONE;
`endif
                        end else if (r_addr == LAST_ADDR) begin
                            w_overflow_next = 1'b1;
                            w_next_state    = S_DONE;
                        end else begin
                            w_next_state = S_HIGH;
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (bus.i_rx_valid) begin
                        w_chk_strobe = 1'b1;
                        w_next_state = S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    w_next_state = S_DONE;
                end
                default: begin
                    w_next_state = S_HIGH;
                end
            endcase
        end
    end

    // State, counter and registered write-port outputs.
    always_ff @(posedge i_clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            r_state    <= S_HIGH;
            r_hi       <= '0;
            r_addr     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_hi       <= w_hi_next;
            r_addr     <= w_addr_next;
            r_wr_en    <= w_wr_en_next;
            r_wr_addr  <= w_wr_addr_next;
            r_wr_data  <= w_wr_data_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign bus.o_wr_en    = r_wr_en;
    assign bus.o_wr_addr  = r_wr_addr;
    assign bus.o_wr_data  = r_wr_data;
    assign bus.o_overflow = r_overflow;
    assign bus.o_done     = (r_state == S_DONE);
    assign bus.o_loading  = (r_state != S_DONE);

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (4-slot memory so the
// overflow boundary is reachable). Checksum cases run when
// PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    localparam int NB_BYTE        = 8;
    localparam int NB_INSTRUCTION = 16;
    localparam int NB_ADDR        = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    program_loader_if #(
        .NB_BYTE        (NB_BYTE),
        .NB_INSTRUCTION (NB_INSTRUCTION),
        .NB_ADDR        (NB_ADDR)
    ) bus ();

    program_loader #(
        .NB_BYTE        (NB_BYTE),
        .NB_INSTRUCTION (NB_INSTRUCTION),
        .NB_ADDR        (NB_ADDR)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [NB_ADDR-1:0]        addr;
        logic [NB_INSTRUCTION-1:0] data;
        int                        cyc;
    } wr_t;
    wr_t log_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.o_wr_en === 1'b1) log_q.push_back('{bus.o_wr_addr, bus.o_wr_data, cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        bus.i_restart = 1'b1;
        @(negedge clk);
        bus.i_restart = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_write(input string tag, input logic [NB_ADDR-1:0] a, input logic [15:0] d);
        check({tag, "_wr_en"},   bus.o_wr_en,   1'b1);
        check({tag, "_wr_addr"}, bus.o_wr_addr, a);
        check({tag, "_wr_data"}, bus.o_wr_data, d);
    endtask

    task automatic check_log(input string tag, input int idx, input logic [NB_ADDR-1:0] a, input logic [15:0] d);
        if (idx < log_q.size()) begin
            check({tag, "_addr"}, log_q[idx].addr, a);
            check({tag, "_data"}, log_q[idx].data, d);
        end else begin
            check({tag, "_present"}, 32'(log_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_en"},    bus.o_wr_en,    1'b0);
        check({tag, "_wr_addr"},  bus.o_wr_addr,  '0);
        check({tag, "_wr_data"},  bus.o_wr_data,  '0);
        check({tag, "_done"},     bus.o_done,     1'b0);
        check({tag, "_overflow"}, bus.o_overflow, 1'b0);
        check({tag, "_error"},    bus.o_error,    1'b0);
        check({tag, "_loading"},  bus.o_loading,  1'b1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        bus.i_restart  = 1'b0;

        // Reset values
        idle(3);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Three-word image ending in HALT
        send_byte(8'h08);
        check("t1_no_early_wr", bus.o_wr_en, 1'b0);
        send_byte(8'h01);
        check_write("t1_w0", 2'd0, 16'h0801);
        check("t1_w0_done", bus.o_done, 1'b0);
        idle(1);
        check("t1_wr_en_one_cycle", bus.o_wr_en, 1'b0);
        check("t1_addr_hold", bus.o_wr_addr, 2'd0);
        send_word(16'h1002);
        check_write("t1_w1", 2'd1, 16'h1002);
        send_word(16'h0000);
        check_write("t1_halt", 2'd2, 16'h0000);
        check("t1_done_with_halt", bus.o_done, 1'b1);
        check("t1_loading_low", bus.o_loading, 1'b0);
        check("t1_no_overflow", bus.o_overflow, 1'b0);
        send_word(16'h1122);
        idle(1);
        check("t1_done_sticky", bus.o_done, 1'b1);
        check("t1_log_size", 32'(log_q.size()), 32'd3);
        check_log("t1_log0", 0, 2'd0, 16'h0801);
        check_log("t1_log2", 2, 2'd2, 16'h0000);

        // Overflow: four non-HALT words fill memory
        pulse_restart();
        check("t2_restart_done", bus.o_done, 1'b0);
        check("t2_restart_loading", bus.o_loading, 1'b1);
        log_q.delete();
        send_word(16'h0101);
        send_word(16'h0202);
        send_word(16'h0303);
        check("t2_w2_no_overflow", bus.o_overflow, 1'b0);
        check("t2_w2_not_done", bus.o_done, 1'b0);
        send_word(16'h0404);
        check_write("t2_w3", 2'd3, 16'h0404);
        check("t2_overflow", bus.o_overflow, 1'b1);
        check("t2_done", bus.o_done, 1'b1);
        send_word(16'h0505);
        idle(1);
        check("t2_fifth_ignored", 32'(log_q.size()), 32'd4);
        check("t2_overflow_sticky", bus.o_overflow, 1'b1);

        // Restart discards a half-assembled word
        pulse_restart();
        check("t3_overflow_cleared", bus.o_overflow, 1'b0);
        log_q.delete();
        send_byte(8'hAA);
        pulse_restart();
        send_word(16'h1234);
        check_write("t3_w0", 2'd0, 16'h1234);
        idle(1);
        check("t3_log_size", 32'(log_q.size()), 32'd1);
        check_log("t3_log0", 0, 2'd0, 16'h1234);

        // Restart has priority over a same-cycle byte
        pulse_restart();
        log_q.delete();
        send_byte(8'h77);
        @(negedge clk);
        bus.i_rx_data  = 8'h55;
        bus.i_rx_valid = 1'b1;
        bus.i_restart  = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        bus.i_restart  = 1'b0;
        check("t4_no_write", bus.o_wr_en, 1'b0);
        send_word(16'hABCD);
        check_write("t4_w0", 2'd0, 16'hABCD);
        idle(1);
        check("t4_log_size", 32'(log_q.size()), 32'd1);

        // Reset mid-load, coinciding with a low-byte strobe
        send_byte(8'h03);
        @(negedge clk);
        bus.i_rx_data  = 8'h04;
        bus.i_rx_valid = 1'b1;
        rst            = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        rst            = 1'b0;
        check_idle_outputs("t5_reset");
        send_word(16'h5678);
        check_write("t5_after_reset", 2'd0, 16'h5678);

        // Back-to-back byte strobes
        pulse_restart();
        log_q.delete();
        begin
            logic [7:0] bytes [6];
            bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                bus.i_rx_data  = bytes[i];
                bus.i_rx_valid = 1'b1;
            end
            @(negedge clk);
            bus.i_rx_valid = 1'b0;
        end
        idle(1);
        check("t6_log_size", 32'(log_q.size()), 32'd3);
        check_log("t6_log0", 0, 2'd0, 16'h1122);
        check_log("t6_log1", 1, 2'd1, 16'h3344);
        check_log("t6_log2", 2, 2'd2, 16'h0000);
        if (log_q.size() == 3) begin
            check("t6_gap01", 32'(log_q[1].cyc - log_q[0].cyc), 32'd2);
            check("t6_gap12", 32'(log_q[2].cyc - log_q[1].cyc), 32'd2);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        check("t6_waiting_checksum", bus.o_done, 1'b0);
`else
        check("t6_done", bus.o_done, 1'b1);
`endif

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum matches (0x01^0x02^0x00^0x00 = 0x03)
        pulse_restart();
        send_word(16'h0102);
        send_word(16'h0000);
        check("t7_wait_chk_done", bus.o_done, 1'b0);
        check("t7_wait_chk_loading", bus.o_loading, 1'b1);
        send_byte(8'h03);
        check("t7_done", bus.o_done, 1'b1);
        check("t7_error", bus.o_error, 1'b0);

        // Checksum mismatch
        pulse_restart();
        send_word(16'h0102);
        send_word(16'h0000);
        send_byte(8'h04);
        check("t8_done", bus.o_done, 1'b1);
        check("t8_error", bus.o_error, 1'b1);
        pulse_restart();
        check("t8_error_cleared", bus.o_error, 1'b0);
`else
        check("t7_error_tied", bus.o_error, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
